uart_bus_arbiter: RTL and testbench

- Shares the UART's memory-mapped register port (uart_sel / uart_wr_enable / uart_addr / wdata_mem / uart_data) between NUM_REQ bus requesters, e.g. core LSU and debug/loader master.
- Each request is a single-beat register read or write. A round-robin FSM sequences the access and returns read data with a one-cycle ack.
- Sits between the requesters and the uart instance. It is the only driver of the UART select/write signals.

---
 rtl/uart_bus_arbiter_if.sv | 39 +++
 rtl/uart_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_uart_bus_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bus_arbiter_if.sv
// rtl/uart_bus_arbiter_if.sv - requester and UART register-port bundle for uart_bus_arbiter
// req_lock exists only when UART_ARB_LOCK_EN is defined.
interface uart_bus_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
`ifdef UART_ARB_LOCK_EN
    logic [NUM_REQ-1:0]        req_lock;
`endif
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rdata;
    logic                      busy;
    logic                      uart_sel;
    logic                      uart_wr_enable;
    logic [ADDR_W-1:0]         uart_addr;
    logic [DATA_W-1:0]         wdata_mem;
    logic [DATA_W-1:0]         uart_data;

    modport slave (
        input  req, req_we, req_addr, req_wdata, uart_data,
`ifdef UART_ARB_LOCK_EN
        input  req_lock,
`endif
        output ack, rdata, busy, uart_sel, uart_wr_enable, uart_addr, wdata_mem
    );

    modport master (
        output req, req_we, req_addr, req_wdata, uart_data,
`ifdef UART_ARB_LOCK_EN
        output req_lock,
`endif
        input  ack, rdata, busy, uart_sel, uart_wr_enable, uart_addr, wdata_mem
    );
endinterface

// File: rtl/uart_bus_arbiter.sv
// rtl/uart_bus_arbiter.sv - round-robin arbiter sharing the UART register port between requesters
// Optional requester lock for atomic sequences is enabled by defining UART_ARB_LOCK_EN.
module uart_bus_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32
) (
    input logic              clock,
    input logic              reset,
    uart_bus_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic [IDX_W-1:0]    cmd_idx_q, cmd_idx_d;
    logic                cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                sel_q, sel_d;
    logic                wr_q, wr_d;
    logic [NUM_REQ-1:0]  eligible;
    logic                found;
    logic [IDX_W-1:0]    winner;

`ifdef UART_ARB_LOCK_EN
    logic locked_q, locked_d;
    logic lock_hold;

    // While locked, only the requester that took the lock may win.
    assign lock_hold = locked_q && bus.req_lock[cmd_idx_q];
    always_comb begin
        eligible = bus.req;
        if (lock_hold) begin
            eligible = bus.req & (NUM_REQ'(1) << cmd_idx_q);
        end
    end
`else
    assign eligible = bus.req;
`endif

    // Highest priority goes to the requester just after the last grant.
    always_comb begin
        logic [IDX_W-1:0] ci;
        found  = 1'b0;
        winner = '0;
        ci     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            ci = IDX_W'((int'(last_grant_q) + 1 + k) % NUM_REQ);
            if (eligible[ci]) begin
                found  = 1'b1;
                winner = ci;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cmd_idx_d    = cmd_idx_q;
        cmd_we_d     = cmd_we_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        rdata_d      = rdata_q;
        ack_d        = '0;
        sel_d        = 1'b0;
        wr_d         = 1'b0;
`ifdef UART_ARB_LOCK_EN
        locked_d     = locked_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef UART_ARB_LOCK_EN
                if (locked_q && !bus.req_lock[cmd_idx_q]) begin
                    locked_d = 1'b0;
                end
`endif
                if (found) begin
                    state_d      = ACCESS;
                    last_grant_d = winner;
                    cmd_idx_d    = winner;
                    cmd_we_d     = bus.req_we[winner];
                    cmd_addr_d   = bus.req_addr[int'(winner)*ADDR_W +: ADDR_W];
                    cmd_wdata_d  = bus.req_wdata[int'(winner)*DATA_W +: DATA_W];
                    sel_d        = 1'b1;
                    wr_d         = bus.req_we[winner];
                end
            end
            ACCESS: begin
                state_d = RESP;
                rdata_d = cmd_we_q ? '0 : bus.uart_data;
                ack_d   = NUM_REQ'(1) << cmd_idx_q;
            end
            RESP: begin
                state_d = IDLE;
`ifdef UART_ARB_LOCK_EN
                locked_d = bus.req_lock[cmd_idx_q];
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            cmd_idx_q    <= '0;
            cmd_we_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            rdata_q      <= '0;
            ack_q        <= '0;
            sel_q        <= 1'b0;
            wr_q         <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            locked_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cmd_idx_q    <= cmd_idx_d;
            cmd_we_q     <= cmd_we_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            rdata_q      <= rdata_d;
            ack_q        <= ack_d;
            sel_q        <= sel_d;
            wr_q         <= wr_d;
`ifdef UART_ARB_LOCK_EN
            locked_q     <= locked_d;
`endif
        end
    end

    assign bus.ack            = ack_q;
    assign bus.rdata          = rdata_q;
    assign bus.busy           = (state_q != IDLE);
    assign bus.uart_sel       = sel_q;
    assign bus.uart_wr_enable = wr_q;
    assign bus.uart_addr      = cmd_addr_q;
    assign bus.wdata_mem      = cmd_wdata_q;
endmodule

// File: tb/tb_uart_bus_arbiter.sv
// tb/tb_uart_bus_arbiter.sv - scoreboard bench for uart_bus_arbiter with a transaction-level round-robin model
// Exercises the lock path as well when UART_ARB_LOCK_EN is defined.
module tb_uart_bus_arbiter;
    localparam int N  = 3;
    localparam int AW = 4;
    localparam int DW = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    uart_bus_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
    uart_bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int           idx;
        logic         we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        bit           first;
    } exp_t;

    exp_t          expq[$];
    exp_t          e;
    logic [DW-1:0] uart_mem [16];
    logic [DW-1:0] ref_mem  [16];
    int            last_g;
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            raise_cyc = 0;
    int            last_ack_cyc = 0;
    logic          sel_prev = 1'b0;

    function automatic logic [DW-1:0] init_val(int a);
        return (a == 8) ? 32'h0000_00A5 : (32'h1000_0000 + 32'(a));
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // UART register file: combinational read, registered write.
    assign bus.uart_data = uart_mem[bus.uart_addr];
    always @(posedge clock) begin
        if (!reset) begin
            for (int a = 0; a < 16; a++) uart_mem[a] <= init_val(a);
        end else if (bus.uart_sel && bus.uart_wr_enable) begin
            uart_mem[bus.uart_addr] <= bus.wdata_mem;
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            if (bus.uart_sel) begin
                check("sel_single_cycle", sel_prev, 0);
                check("busy_in_access", bus.busy, 1);
                if (expq.size() == 0) begin
                    check("sel_unexpected", 1, 0);
                end else begin
                    check("uart_addr", bus.uart_addr, expq[0].addr);
                    check("uart_wr_enable", bus.uart_wr_enable, expq[0].we);
                    if (expq[0].we) check("wdata_mem", bus.wdata_mem, expq[0].wdata);
                end
            end
            if (bus.ack != 0) begin
                check("ack_after_sel", sel_prev, 1);
                check("busy_in_resp", bus.busy, 1);
                if (expq.size() == 0) begin
                    check("ack_unexpected", bus.ack, 0);
                end else begin
                    e = expq.pop_front();
                    check("ack_idx", bus.ack, 64'(1) << e.idx);
                    check("rdata", bus.rdata, e.rdata);
                    if (e.first) check("first_ack_latency", cyc - raise_cyc, 2);
                    else         check("back_to_back_spacing", cyc - last_ack_cyc, 3);
                    last_ack_cyc = cyc;
                end
            end
            sel_prev = bus.uart_sel;
        end else begin
            sel_prev = 1'b0;
        end
    end

    task automatic model_init();
        for (int a = 0; a < 16; a++) ref_mem[a] = init_val(a);
        last_g = N - 1;
    endtask

    task automatic push_exp(int idx, logic we, logic [AW-1:0] addr, logic [DW-1:0] wd, bit first);
        exp_t x;
        x.idx = idx; x.we = we; x.addr = addr; x.wdata = wd; x.first = first;
        if (we) begin
            ref_mem[addr] = wd;
            x.rdata = '0;
        end else begin
            x.rdata = ref_mem[addr];
        end
        expq.push_back(x);
    endtask

    task automatic check_reset_outputs();
        check("rst_ack", bus.ack, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_sel", bus.uart_sel, 0);
        check("rst_wr", bus.uart_wr_enable, 0);
        check("rst_addr", bus.uart_addr, 0);
        check("rst_wdata", bus.wdata_mem, 0);
    endtask

    // All masked requesters raise together; the model serves them round-robin from last_g.
    task automatic run_batch(logic [N-1:0] mask, logic [N-1:0] we,
                             logic [N*AW-1:0] addr, logic [N*DW-1:0] wd);
        logic [N-1:0] pend = mask;
        int p = last_g;
        bit first = 1'b1;
        while (pend != 0) begin
            for (int k = 1; k <= N; k++) begin
                int c = (p + k) % N;
                if (pend[c]) begin
                    push_exp(c, we[c], addr[c*AW +: AW], wd[c*DW +: DW], first);
                    first = 1'b0;
                    pend[c] = 1'b0;
                    p = c;
                    break;
                end
            end
        end
        last_g = p;
        @(posedge clock); #1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req       = mask;
        raise_cyc     = cyc;
        for (int t = 0; t < 4 * N + 4 && bus.req != 0; t++) begin
            @(negedge clock);
            bus.req = bus.req & ~bus.ack;
        end
        if (bus.req != 0) begin
            check("batch_timeout", bus.req, 0);
            bus.req = '0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N*AW-1:0] ra;
        logic [N*DW-1:0] rw;
        bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0;
`ifdef UART_ARB_LOCK_EN
        bus.req_lock = '0;
`endif
        model_init();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs();
        reset = 1'b1;

        run_batch(3'b001, 3'b001, {4'h0, 4'h0, 4'h4}, {32'h0, 32'h0, 32'h0000_01B2});
        run_batch(3'b010, 3'b000, {4'h0, 4'h8, 4'h0}, {32'h0, 32'h0, 32'h0});
        repeat (4) @(negedge clock);
        check("rdata_hold", bus.rdata, 32'hA5);

        run_batch(3'b011, 3'b000, {4'h0, 4'h4, 4'h8}, {32'h0, 32'h0, 32'h0});
        run_batch(3'b011, 3'b011, {4'h0, 4'h5, 4'h6}, {32'h0, 32'h55, 32'h66});
        run_batch(3'b111, 3'b000, {4'h6, 4'h5, 4'h4}, {32'h0, 32'h0, 32'h0});

        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("idle_quiet", {bus.uart_sel, bus.uart_wr_enable, bus.ack, bus.busy}, 0);
        end

        @(posedge clock); #1;
        bus.req_we = 3'b000; bus.req_addr = {4'h0, 4'h8, 4'h0}; bus.req = 3'b010;
        push_exp(1, 1'b0, 4'h8, 32'h0, 1'b1);
        raise_cyc = cyc;
        for (int t = 0; t < 6 && !bus.uart_sel; t++) @(negedge clock);
        check("reset_test_reached_access", bus.uart_sel, 1);
        reset = 1'b0;
        bus.req = '0;
        @(posedge clock); #1;
        expq.delete();
        model_init();
        check_reset_outputs();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("no_ack_after_reset", bus.ack, 0);
        end
        run_batch(3'b100, 3'b100, {4'h9, 4'h0, 4'h0}, {32'hDEAD_BEEF, 32'h0, 32'h0});
        run_batch(3'b001, 3'b000, {4'h0, 4'h0, 4'h9}, {32'h0, 32'h0, 32'h0});

        for (int i = 0; i < 40; i++) begin
            for (int r = 0; r < N; r++) begin
                ra[r*AW +: AW] = AW'($urandom_range(0, 15));
                rw[r*DW +: DW] = $urandom;
            end
            run_batch(N'($urandom_range(1, (1 << N) - 1)), N'($urandom), ra, rw);
        end

`ifdef UART_ARB_LOCK_EN
        push_exp(0, 1'b1, 4'h3, 32'h0000_0C01, 1'b1);
        push_exp(0, 1'b1, 4'h3, 32'h0000_0C01, 1'b0);
        push_exp(0, 1'b1, 4'h3, 32'h0000_0C01, 1'b0);
        push_exp(1, 1'b0, 4'h3, 32'h0, 1'b0);
        last_g = 1;
        @(posedge clock); #1;
        bus.req_we = 3'b001; bus.req_addr = {4'h0, 4'h3, 4'h3}; bus.req_wdata = {64'h0, 32'h0000_0C01};
        bus.req_lock = 3'b001; bus.req = 3'b001;
        raise_cyc = cyc;
        for (int n = 0; n < 4; n++) begin
            for (int t = 0; t < 12 && bus.ack == 0; t++) @(negedge clock);
            check("lock_ack_seen", bus.ack != 0, 1);
            if (n < 3) bus.req[0] = 1'b0;
            if (n == 2) bus.req_lock[0] = 1'b0;
            if (n == 3) bus.req[1] = 1'b0;
            @(posedge clock); #1;
            if (n < 2) bus.req[0] = 1'b1;
            if (n == 0) bus.req[1] = 1'b1;
        end
        bus.req = '0;
`endif

        repeat (5) @(negedge clock);
        check("queue_drained", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
